// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES request controller.
// Block width, mode encodings and the controller state enum.
package aes_ctrl_pkg;

  localparam int AES_BLK_W = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    KEYLD,
    KEYWAIT,
    LOAD,
    WAIT_DONE,
    RESP
  } state_t;

endpackage

// File: rtl/aes_ctrl_timer.sv
// Loadable saturating down-counter; expired is high whenever the count sits at zero.
// Shared by the key-expansion wait and the done timeout.
module aes_ctrl_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/aes_req_ctrl.sv
// Single-outstanding request sequencer for the AES core: ld pulses, optional key
// expansion wait, done timeout, and a held response until the consumer takes it.
module aes_req_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int KEY_EXP_CYCLES = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_mode,
  input  logic [AES_BLK_W-1:0] req_key,
  input  logic [AES_BLK_W-1:0] req_text,
  output logic                 aes_mode,
  output logic                 aes_ld,
  output logic [AES_BLK_W-1:0] aes_key,
  output logic [AES_BLK_W-1:0] aes_text_in,
  input  logic [AES_BLK_W-1:0] aes_text_out,
  input  logic                 aes_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [AES_BLK_W-1:0] rsp_text,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int TMAX = (TIMEOUT_CYCLES > KEY_EXP_CYCLES) ? TIMEOUT_CYCLES : KEY_EXP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  // The timer is loaded one short so expiry lands in the last cycle of the
  // waiting state, giving exactly N cycles in KEYWAIT / WAIT_DONE.
  localparam logic [TW-1:0] KEY_LOAD_VAL = TW'(KEY_EXP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD_VAL = TW'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   aes_mode_q, aes_mode_d;
  logic                   aes_ld_q, aes_ld_d;
  logic [AES_BLK_W-1:0]   aes_key_q, aes_key_d;
  logic [AES_BLK_W-1:0]   aes_text_in_q, aes_text_in_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [AES_BLK_W-1:0]   rsp_text_q, rsp_text_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   busy_q, busy_d;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_expired;

  aes_ctrl_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    aes_mode_d    = aes_mode_q;
    aes_key_d     = aes_key_q;
    aes_text_in_d = aes_text_in_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_text_d    = rsp_text_q;
    rsp_err_d     = rsp_err_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          aes_mode_d    = req_mode;
          aes_key_d     = req_key;
          aes_text_in_d = req_text;
          state_d       = (req_mode == MODE_DEC) ? KEYLD : LOAD;
        end
      end
      KEYLD: begin
        tmr_load = 1'b1;
        tmr_val  = KEY_LOAD_VAL;
        state_d  = KEYWAIT;
      end
      KEYWAIT: begin
        if (tmr_expired) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        tmr_load = 1'b1;
        tmr_val  = TMO_LOAD_VAL;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        // done takes priority over a coinciding timeout
        if (aes_done) begin
          rsp_text_d  = aes_text_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (tmr_expired) begin
          rsp_text_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs follow the next state so they line up with it.
    aes_ld_d = (state_d == KEYLD) || (state_d == LOAD);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      aes_mode_q    <= 1'b0;
      aes_ld_q      <= 1'b0;
      aes_key_q     <= '0;
      aes_text_in_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_text_q    <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      aes_mode_q    <= aes_mode_d;
      aes_ld_q      <= aes_ld_d;
      aes_key_q     <= aes_key_d;
      aes_text_in_q <= aes_text_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_text_q    <= rsp_text_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign aes_mode    = aes_mode_q;
  assign aes_ld      = aes_ld_q;
  assign aes_key     = aes_key_q;
  assign aes_text_in = aes_text_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_text    = rsp_text_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_aes_req_ctrl.sv
// Bench for aes_req_ctrl: known-answer core model, directed table, reset/stray-done
// sequence and randomized requests checked against a latency/result reference.
module tb_aes_req_ctrl;
  import aes_ctrl_pkg::*;

  localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] A5  = {16{8'ha5}};
  localparam int           TMO = 64;
  localparam int           KEX = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_mode = 1'b0;
  logic [127:0] req_key = '0;
  logic [127:0] req_text = '0;
  logic         aes_mode;
  logic         aes_ld;
  logic [127:0] aes_key;
  logic [127:0] aes_text_in;
  logic [127:0] aes_text_out = '0;
  logic         aes_done;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_text;
  logic         rsp_err;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  aes_req_ctrl #(.TIMEOUT_CYCLES(TMO), .KEY_EXP_CYCLES(KEX)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_key      (req_key),
    .req_text     (req_text),
    .aes_mode     (aes_mode),
    .aes_ld       (aes_ld),
    .aes_key      (aes_key),
    .aes_text_in  (aes_text_in),
    .aes_text_out (aes_text_out),
    .aes_done     (aes_done),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_text     (rsp_text),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Core stand-in: answers known FIPS-197 vectors, otherwise a simple mix.
  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k,
                                           input logic [127:0] t);
    if (k == K && m == MODE_ENC && t == P) return C;
    if (k == K && m == MODE_DEC && t == C) return P;
    return {t[63:0], t[127:64]} ^ k ^ {128{m}};
  endfunction

  // done is raised in the lat-th cycle after the data ld pulse (lat 0 = never).
  int           core_lat = 0;
  bit           core_force_en = 1'b0;
  logic         core_done = 1'b0;
  logic         stray_done = 1'b0;
  bit           armed = 1'b0;
  int           ldn = 0;
  int           wcnt = 0;
  assign aes_done = core_done | stray_done;

  always @(negedge clk) begin
    if (rst) begin
      armed = 1'b0; ldn = 0; wcnt = 0; core_done = 1'b0;
    end else begin
      if (!busy) ldn = 0;
      if (aes_ld) begin
        ldn++;
        armed = (aes_mode == MODE_ENC) || (ldn == 2);
        wcnt = 0;
        core_done = 1'b0;
        if (armed) aes_text_out = core_force_en ? A5 : core_fn(aes_mode, aes_key, aes_text_in);
      end else begin
        wcnt++;
        core_done = armed && (core_lat != 0) && (wcnt == core_lat);
        if (core_done) armed = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected response derived from the core latency alone.
  function automatic void ref_model(input logic m, input logic [127:0] k, input logic [127:0] t,
                                    input int lat, output logic err, output logic [127:0] txt,
                                    output int rlat);
    err  = (lat == 0) || (lat > TMO);
    txt  = err ? 128'h0 : core_fn(m, k, t);
    rlat = err ? TMO + 1 : lat + 1;
  endfunction

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic do_req(input string tag, input logic m, input logic [127:0] k,
                        input logic [127:0] t, input int lat, input bit frc, input int hold,
                        input bit pend, input logic pm, input logic [127:0] pk,
                        input logic [127:0] pt, input logic exp_err,
                        input logic [127:0] exp_text, input int exp_rlat);
    int c, ld1, ld2, nld, rv;
    bit hs, bad_op, bad_rdy, unstable, rdy_hold;
    logic [127:0] held_text;
    logic held_err;
    core_lat = lat; core_force_en = frc;
    req_valid = 1'b1; req_mode = m; req_key = k; req_text = t;
    hs = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin hs = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "/accept"}, 128'(hs), 128'd1);
    if (!hs) begin req_valid = 1'b0; return; end
    c = 0; ld1 = 0; ld2 = 0; nld = 0; rv = 0; bad_op = 1'b0; bad_rdy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      c++;
      req_valid = 1'b0;
      if (aes_ld) begin nld++; if (nld == 1) ld1 = c; else ld2 = c; end
      if (aes_mode !== m || aes_key !== k || aes_text_in !== t) bad_op = 1'b1;
      if (req_ready) bad_rdy = 1'b1;
      if (rsp_valid) begin rv = c; break; end
    end
    chk({tag, "/first_ld_cycle"}, 128'(ld1), 128'd1);
    chk({tag, "/ld_pulses"}, 128'(nld), m ? 128'd2 : 128'd1);
    if (m == MODE_DEC) chk({tag, "/key_gap"}, 128'(ld2 - ld1 - 1), 128'(KEX));
    chk({tag, "/operands_stable"}, 128'(bad_op), 128'd0);
    chk({tag, "/req_ready_low_busy"}, 128'(bad_rdy), 128'd0);
    chk({tag, "/rsp_latency"}, 128'(rv - (m ? ld2 : ld1)), 128'(exp_rlat));
    chk({tag, "/rsp_err"}, 128'(rsp_err), 128'(exp_err));
    chk({tag, "/rsp_text"}, rsp_text, exp_text);
    held_text = rsp_text; held_err = rsp_err; unstable = 1'b0; rdy_hold = 1'b0;
    if (pend) begin req_valid = 1'b1; req_mode = pm; req_key = pk; req_text = pt; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_text !== held_text || rsp_err !== held_err) unstable = 1'b1;
      if (req_ready || busy !== 1'b1) rdy_hold = 1'b1;
    end
    if (hold > 0) begin
      chk({tag, "/hold_rsp_stable"}, 128'(unstable), 128'd0);
      chk({tag, "/hold_req_blocked"}, 128'(rdy_hold), 128'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "/rsp_valid_drop"}, 128'(rsp_valid), 128'd0);
    chk({tag, "/req_ready_after"}, 128'(req_ready), 128'd1);
    chk({tag, "/idle_after"}, 128'(busy), 128'd0);
  endtask

  typedef struct {
    logic         m;
    logic [127:0] k;
    logic [127:0] t;
    int           lat;
    bit           frc;
    int           hold;
    logic         exp_err;
    logic [127:0] exp_text;
    int           exp_rlat;
  } vec_t;

  vec_t tv[8];

  initial begin
    logic         m, e_err;
    logic [127:0] k, t, e_txt;
    int           lat, e_rlat, hold;
    bit           bad, pend;
    int           nx;

    tv[0] = '{MODE_ENC, K, P, 5,  1'b0, 0, 1'b0, C,     6};
    tv[1] = '{MODE_DEC, K, C, 10, 1'b0, 0, 1'b0, P,     11};
    tv[2] = '{MODE_ENC, K, P, 3,  1'b0, 5, 1'b0, C,     4};
    tv[3] = '{MODE_ENC, K, P, 0,  1'b0, 0, 1'b1, '0,    65};
    tv[4] = '{MODE_ENC, K, P, 7,  1'b0, 0, 1'b0, C,     8};
    tv[5] = '{MODE_DEC, K, C, 64, 1'b1, 0, 1'b0, A5,    65};
    tv[6] = '{MODE_ENC, K, P, 65, 1'b0, 2, 1'b1, '0,    65};
    tv[7] = '{MODE_ENC, K, P, 1,  1'b0, 0, 1'b0, C,     2};

    @(negedge clk);
    chk("reset/req_ready", 128'(req_ready), 128'd1);
    chk("reset/busy", 128'(busy), 128'd0);
    chk("reset/rsp_valid", 128'(rsp_valid), 128'd0);
    chk("reset/aes_ld", 128'(aes_ld), 128'd0);
    chk("reset/aes_key", aes_key, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      nx = (i < 7) ? i + 1 : i;
      pend = (tv[i].hold > 0) && (i < 7);
      do_req($sformatf("vec%0d", i), tv[i].m, tv[i].k, tv[i].t, tv[i].lat, tv[i].frc,
             tv[i].hold, pend, tv[nx].m, tv[nx].k, tv[nx].t,
             tv[i].exp_err, tv[i].exp_text, tv[i].exp_rlat);
    end

    // Reset while waiting for done, then a stray done in IDLE.
    core_lat = 0; core_force_en = 1'b0;
    req_valid = 1'b1; req_mode = MODE_ENC; req_key = K; req_text = P;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst/busy_before", 128'(busy), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst/aes_ld", 128'(aes_ld), 128'd0);
    chk("rst/aes_mode", 128'(aes_mode), 128'd0);
    chk("rst/aes_key", aes_key, 128'd0);
    chk("rst/aes_text_in", aes_text_in, 128'd0);
    chk("rst/rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst/rsp_text", rsp_text, 128'd0);
    chk("rst/rsp_err", 128'(rsp_err), 128'd0);
    chk("rst/busy", 128'(busy), 128'd0);
    chk("rst/req_ready", 128'(req_ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/req_ready_after", 128'(req_ready), 128'd1);
    bad = 1'b0;
    stray_done = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || busy) bad = 1'b1;
    end
    stray_done = 1'b0;
    @(negedge clk);
    if (rsp_valid || busy) bad = 1'b1;
    chk("stray_done_ignored", 128'(bad), 128'd0);
    do_req("post_rst", MODE_ENC, K, P, 9, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0, C, 10);

    for (int i = 0; i < 25; i++) begin
      m    = 1'($urandom_range(0, 1));
      k    = {$urandom, $urandom, $urandom, $urandom};
      t    = {$urandom, $urandom, $urandom, $urandom};
      lat  = $urandom_range(0, 70);
      hold = $urandom_range(0, 3);
      ref_model(m, k, t, lat, e_err, e_txt, e_rlat);
      do_req($sformatf("rnd%0d", i), m, k, t, lat, 1'b0, hold, 1'b0, 1'b0, '0, '0,
             e_err, e_txt, e_rlat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_req_ctrl.md
Name: aes_req_ctrl

Overview:
Host-side initiator for the AES core interface (mode, ld, key, text_in -> text_out, done). It accepts one 128-bit encrypt/decrypt request at a time over a valid/ready handshake and sequences ld pulses to the core. For decrypt it adds a key-expansion phase. It then waits for done with a timeout and returns the result over a second valid/ready handshake. It sits between the system bus adapter and the AES core top.

Parameters:
TIMEOUT_CYCLES, 64, WAIT_DONE cycles without aes_done before the request is aborted with error.
KEY_EXP_CYCLES, 12, idle cycles between the decrypt key-load ld pulse and the data-load ld pulse.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request valid
req_ready  output  1  request ready
req_mode  input  1  0 encrypt, 1 decrypt
req_key  input  128  key
req_text  input  128  input block
aes_mode  output  1  to core mode
aes_ld  output  1  to core ld, one-cycle pulses
aes_key  output  128  to core key
aes_text_in  output  128  to core text_in
aes_text_out  input  128  from core text_out
aes_done  input  1  from core done
rsp_valid  output  1  response valid
rsp_ready  input  1  response ready
rsp_text  output  128  result block
rsp_err  output  1  1 = timeout abort
busy  output  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; aes_ld, aes_mode, aes_key, aes_text_in, rsp_valid, rsp_text, rsp_err, busy all 0. req_ready = (state==IDLE), so it reads 1 while in reset.
- Output registering: all outputs are registered except req_ready.
- States: IDLE, KEYLD, KEYWAIT, LOAD, WAIT_DONE, RESP.
- IDLE:
  - On req_valid & req_ready, capture mode, key and text into aes_mode, aes_key and aes_text_in.
  - Go to KEYLD if mode=1, otherwise to LOAD.
  - aes_done while in IDLE is ignored.
- KEYLD: aes_ld=1 for exactly one cycle. Load the timer with KEY_EXP_CYCLES, then go to KEYWAIT.
- KEYWAIT: aes_ld=0. Stay until the timer expires, i.e. exactly KEY_EXP_CYCLES cycles, then go to LOAD.
- LOAD: aes_ld=1 for exactly one cycle. Load the timer with TIMEOUT_CYCLES, then go to WAIT_DONE.
- Operand stability: aes_mode, aes_key and aes_text_in stay stable from capture until RESP is exited.
- WAIT_DONE:
  - If aes_done is sampled 1: rsp_text <= aes_text_out, rsp_err <= 0, rsp_valid <= 1, go to RESP.
  - Otherwise, on timer expiry after TIMEOUT_CYCLES cycles: rsp_text <= 0, rsp_err <= 1, rsp_valid <= 1, go to RESP.
  - If aes_done and timer expiry coincide, done wins (err=0).
- RESP:
  - rsp_valid, rsp_text and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - req_ready rises the following cycle; there is no same-cycle bypass.
- Latency, encrypt: aes_ld is high in the cycle after the request handshake edge. rsp_valid rises in the cycle after aes_done is sampled.
- Latency, decrypt: first aes_ld pulse in the cycle after the handshake edge. Then KEY_EXP_CYCLES low cycles, then the second pulse.
- Backpressure: only one request is in flight. req_ready=0 in every non-IDLE state.
- Reset mid-operation: immediate return to the reset values; the in-flight request is dropped with no response. The core shares rst.
- Timer width: $clog2(max(TIMEOUT_CYCLES, KEY_EXP_CYCLES)+1). Down-counter, no wrap: it saturates at 0 and flags expiry at 0.

Decomposition:
- Package aes_ctrl_pkg:
  - AES_BLK_W=128;
  - MODE_ENC=1'b0 and MODE_DEC=1'b1;
  - the state typedef enum (IDLE, KEYLD, KEYWAIT, LOAD, WAIT_DONE, RESP).
- Sub-module aes_ctrl_timer: loadable down-counter with load, load_val and expired outputs. It is shared by KEYWAIT and WAIT_DONE.

Test Plan:
- Encrypt, real core: key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff -> rsp_text 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err 0, exactly one aes_ld pulse.
- Decrypt, same key, text 69c4e0d86a7b0430d8cdb78070b4c55a -> rsp_text 00112233445566778899aabbccddeeff. Two aes_ld pulses separated by exactly 12 low cycles; aes_mode=1 throughout.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 pending -> rsp_valid and rsp_text stable, req_ready=0, second request not accepted until the cycle after the rsp handshake.
- Timeout: core model never asserts done -> rsp_valid rises with rsp_err=1, rsp_text=0 after 64 WAIT_DONE cycles. The next request is accepted and completes normally.
- Coincidence: core model asserts done with text_out=a5a5...a5 on the cycle the timer expires -> rsp_err=0, rsp_text=a5a5...a5.
- Reset and stray done:
  - Assert rst during WAIT_DONE -> all outputs 0 and busy=0 asynchronously; req_ready=1 after release.
  - Stray aes_done in IDLE -> no rsp_valid.
  - A following encrypt completes correctly.
